// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: instruction-memory handshake, decode-side control and the
// registered fetch/decode outputs with their decoded MIPS fields.
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;
  logic [5:0]  opCode;
  logic [5:0]  func;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [15:0] imm;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    input  stall, redirect, redirect_pc,
    output id_valid, id_instr, id_pc4,
    output opCode, func, rs, rt, rd, shamt, imm
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    output stall, redirect, redirect_pc,
    input  id_valid, id_instr, id_pc4,
    input  opCode, func, rs, rt, rd, shamt, imm
  );
endinterface

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: one outstanding imem read, one-entry skid buffer for
// stalls, and redirect handling that drains an in-flight read before refetching.
//
// state | meaning
// FETCH | issue/await a read at r_pc; deliver to decode or skid on stall
// HOLD  | skid holds a fetched word, waiting for stall to drop
// DROP  | redirected while a read was in flight; wait for its ack and discard
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic           clk,
  input logic           rst,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t      r_state,      w_state_nxt;
  logic [31:0] r_pc,         w_pc_nxt;
  logic [31:0] r_addr,       w_addr_nxt;
  logic        r_req,        w_req_nxt;
  logic        r_id_valid,   w_id_valid_nxt;
  logic [31:0] r_id_instr,   w_id_instr_nxt;
  logic [31:0] r_id_pc4,     w_id_pc4_nxt;
  logic        r_skid_valid, w_skid_valid_nxt;
  logic [31:0] r_skid_instr, w_skid_instr_nxt;
  logic [31:0] r_skid_pc4,   w_skid_pc4_nxt;

  logic [31:0] w_pc4;
  logic [31:0] w_redir_pc;
  logic        w_delivered;

  assign w_pc4      = r_pc + 32'd4;
  assign w_redir_pc = bus.redirect_pc & 32'hFFFF_FFFC;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= FETCH;
      r_pc         <= RESET_PC;
      r_addr       <= RESET_PC;
      r_req        <= 1'b0;
      r_id_valid   <= 1'b0;
      r_id_instr   <= 32'h0;
      r_id_pc4     <= 32'h0;
      r_skid_valid <= 1'b0;
      r_skid_instr <= 32'h0;
      r_skid_pc4   <= 32'h0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_addr       <= w_addr_nxt;
      r_req        <= w_req_nxt;
      r_id_valid   <= w_id_valid_nxt;
      r_id_instr   <= w_id_instr_nxt;
      r_id_pc4     <= w_id_pc4_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_skid_instr <= w_skid_instr_nxt;
      r_skid_pc4   <= w_skid_pc4_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_addr_nxt       = r_addr;
    w_req_nxt        = r_req;
    w_id_valid_nxt   = r_id_valid;
    w_id_instr_nxt   = r_id_instr;
    w_id_pc4_nxt     = r_id_pc4;
    w_skid_valid_nxt = r_skid_valid;
    w_skid_instr_nxt = r_skid_instr;
    w_skid_pc4_nxt   = r_skid_pc4;
    w_delivered      = 1'b0;

    case (r_state)
      FETCH: begin
        if (bus.redirect) begin
          w_pc_nxt         = w_redir_pc;
          w_skid_valid_nxt = 1'b0;
          // A read already on the bus must complete before the new target goes out
          if (r_req && !bus.imem_ack) begin
            w_state_nxt = DROP;
          end else begin
            w_req_nxt = 1'b0;
          end
        end else if (r_req && bus.imem_ack) begin
          w_pc_nxt  = w_pc4;
          w_req_nxt = 1'b0;
          if (bus.stall) begin
            w_skid_valid_nxt = 1'b1;
            w_skid_instr_nxt = bus.imem_rdata;
            w_skid_pc4_nxt   = w_pc4;
            w_state_nxt      = HOLD;
          end else begin
            w_id_valid_nxt = 1'b1;
            w_id_instr_nxt = bus.imem_rdata;
            w_id_pc4_nxt   = w_pc4;
            w_delivered    = 1'b1;
          end
        end else if (!r_req && !r_skid_valid) begin
          w_req_nxt  = 1'b1;
          w_addr_nxt = r_pc;
        end
      end

      HOLD: begin
        if (bus.redirect) begin
          w_pc_nxt         = w_redir_pc;
          w_skid_valid_nxt = 1'b0;
          w_state_nxt      = FETCH;
        end else if (!bus.stall) begin
          w_id_valid_nxt   = 1'b1;
          w_id_instr_nxt   = r_skid_instr;
          w_id_pc4_nxt     = r_skid_pc4;
          w_skid_valid_nxt = 1'b0;
          w_delivered      = 1'b1;
          w_state_nxt      = FETCH;
        end
      end

      DROP: begin
        if (bus.redirect) begin
          w_pc_nxt = w_redir_pc;
        end
        if (bus.imem_ack) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = FETCH;
        end
      end

      default: begin
        w_state_nxt = FETCH;
        w_req_nxt   = 1'b0;
      end
    endcase

    // Bubble into decode on a flush, or whenever decode is free and nothing arrived
    if (!w_delivered && (bus.redirect || !bus.stall)) begin
      w_id_valid_nxt = 1'b0;
      w_id_instr_nxt = 32'h0;
    end
  end

  assign bus.imem_req  = r_req;
  assign bus.imem_addr = r_addr;
  assign bus.id_valid  = r_id_valid;
  assign bus.id_instr  = r_id_instr;
  assign bus.id_pc4    = r_id_pc4;

  assign bus.opCode = r_id_instr[31:26];
  assign bus.rs     = r_id_instr[25:21];
  assign bus.rt     = r_id_instr[20:16];
  assign bus.rd     = r_id_instr[15:11];
  assign bus.shamt  = r_id_instr[10:6];
  assign bus.func   = r_id_instr[5:0];
  assign bus.imm    = r_id_instr[15:0];

endmodule
